spi_tx_fifo: RTL and testbench

- Transmit-side buffer that feeds SPIxIF.
- Host/processor side pushes 9-bit words with WE/DI; SPIxIF pops them through its DAV/FRE/TD handshake.
- First-word-fall-through: the word at the head of the FIFO is always presented on TD while DAV is high.
- Provides fill level, full/half-full flags and sticky overflow/underflow error flags for the host status register.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_fifo_dpram.sv | 39 +++
 rtl/spi_tx_fifo.sv | 125 ++++++++++++
 tb/tb_spi_tx_fifo.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Purpose : shared SPI constants (word width, default FIFO address width, control bit).
// Latency : n/a (package only).
// Backpressure: n/a.
package spi_pkg;

   // SPI word: 8 data bits plus one frame/SS control bit on top
   localparam int SPI_WORD_W  = 9;
   localparam int SPI_FIFO_AW = 4;
   localparam int SPI_CTL_BIT = 8;

   typedef logic [SPI_WORD_W-1:0] spi_word_t;

   // Depth of a FIFO built on an address of the given width
   function automatic int spi_fifo_depth(input int aw);
      return 1 << aw;
   endfunction

   // Frame/SS control bit carried alongside each data byte
   function automatic logic spi_ctl(input spi_word_t w);
      return w[SPI_CTL_BIT];
   endfunction

endpackage : spi_pkg

// File: rtl/spi_fifo_dpram.sv
// Purpose : generic pWidth x 2**pAddr RAM, synchronous write, asynchronous read.
// Latency : write visible on rdata from the edge after we; read is combinational.
// Backpressure: none; caller owns address and enable sequencing.
//
// Ports:
//   Clk    - write clock
//   we     - write enable, stores wdata at waddr on rising edge
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - mem[raddr], combinational
//
// No reset on the array so it maps onto distributed RAM; shared by the
// transmit and receive FIFOs.
module spi_fifo_dpram #(
   parameter int pWidth = 9,
   parameter int pAddr  = 4
) (
   input  logic              Clk,
   input  logic              we,
   input  logic [pAddr-1:0]  waddr,
   input  logic [pWidth-1:0] wdata,
   input  logic [pAddr-1:0]  raddr,
   output logic [pWidth-1:0] rdata
);

   localparam int cDepth = 1 << pAddr;

   logic [pWidth-1:0] mem [0:cDepth-1];

   always_ff @(posedge Clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : spi_fifo_dpram

// File: rtl/spi_tx_fifo.sv
// Purpose : first-word-fall-through transmit FIFO between host writes and SPIxIF.
// Latency : word written on edge k is on TD with DAV=1 after edge k; pop shows next word same cycle.
// Backpressure: FF blocks lone writes (dropped, OVF sticky); pop while empty ignored (UNF sticky).
//
// Ports:
//   Clk, Rst  - clock, asynchronous active-high reset
//   Clr       - synchronous flush; beats WE/FRE on the same edge
//   WE, DI    - host write strobe and data
//   FF, HF    - full / half-full (registered)
//   Cnt       - occupancy 0..2**pAddr (registered)
//   OVF, UNF  - sticky overflow / underflow flags
//   DAV, FRE  - data available / SPIxIF pop strobe
//   TD        - head word, valid while DAV
module spi_tx_fifo
   import spi_pkg::*;
#(
   parameter int pWidth = SPI_WORD_W,
   parameter int pAddr  = SPI_FIFO_AW
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Clr,
   input  logic              WE,
   input  logic [pWidth-1:0] DI,
   output logic              FF,
   output logic              HF,
   output logic [pAddr:0]    Cnt,
   output logic              OVF,
   output logic              UNF,
   output logic              DAV,
   input  logic              FRE,
   output logic [pWidth-1:0] TD
);

   // Full and half-full thresholds in Cnt width
   localparam logic [pAddr:0] cFull = {1'b1, {pAddr{1'b0}}};
   localparam logic [pAddr:0] cHalf = {2'b01, {(pAddr-1){1'b0}}};

   logic [pAddr-1:0] wptr;
   logic [pAddr-1:0] rptr;
   logic [pAddr:0]   cnt_q;
   logic [pAddr:0]   cnt_nxt;
   logic             dav_q;
   logic             ff_q;
   logic             hf_q;
   logic             ovf_q;
   logic             unf_q;
   logic             wr_ok;
   logic             rd_ok;
   logic             ram_we;

   // A pop on the same edge frees the slot, so a write into a full FIFO
   // is still accepted when FRE is high. When full, DAV is necessarily
   // high, so that pop is accepted as well.
   assign wr_ok  = WE & (~ff_q | FRE);
   assign rd_ok  = FRE & dav_q;

   // A flush discards any write presented with it
   assign ram_we = wr_ok & ~Clr;

   always_comb begin
      cnt_nxt = cnt_q;
      if (wr_ok & ~rd_ok) begin
         cnt_nxt = cnt_q + 1'b1;
      end else if (rd_ok & ~wr_ok) begin
         cnt_nxt = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt_q <= '0;
         dav_q <= 1'b0;
         ff_q  <= 1'b0;
         hf_q  <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (Clr) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt_q <= '0;
         dav_q <= 1'b0;
         ff_q  <= 1'b0;
         hf_q  <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_ok) begin
            rptr <= rptr + 1'b1;
         end
         cnt_q <= cnt_nxt;
         // Status flags track the post-edge occupancy so they never lag Cnt
         dav_q <= (cnt_nxt != '0);
         ff_q  <= (cnt_nxt == cFull);
         hf_q  <= (cnt_nxt >= cHalf);
         ovf_q <= ovf_q | (WE & ff_q & ~FRE);
         unf_q <= unf_q | (FRE & ~dav_q);
      end
   end

   spi_fifo_dpram #(
      .pWidth (pWidth),
      .pAddr  (pAddr)
   ) u_ram (
      .Clk   (Clk),
      .we    (ram_we),
      .waddr (wptr),
      .wdata (DI),
      .raddr (rptr),
      .rdata (TD)
   );

   assign Cnt = cnt_q;
   assign DAV = dav_q;
   assign FF  = ff_q;
   assign HF  = hf_q;
   assign OVF = ovf_q;
   assign UNF = unf_q;

endmodule : spi_tx_fifo

// File: tb/tb_spi_tx_fifo.sv
// Purpose : self-checking bench for spi_tx_fifo against a queue-based model.
// Latency : inputs driven 1 ns after a rising edge, outputs checked 1 ns after the next.
// Backpressure: model derives accept/drop decisions from its own occupancy.
module tb_spi_tx_fifo;

   localparam int W     = 9;
   localparam int A     = 4;
   localparam int DEPTH = 16;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic         Clr = 1'b0;
   logic         WE  = 1'b0;
   logic [W-1:0] DI  = '0;
   logic         FRE = 1'b0;
   logic         FF, HF, OVF, UNF, DAV;
   logic [A:0]   Cnt;
   logic [W-1:0] TD;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: contents as an ordered list plus the two sticky flags
   int q[$];
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   always #5 Clk = ~Clk;

   spi_tx_fifo #(.pWidth(W), .pAddr(A)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .Clr (Clr),
      .WE  (WE),
      .DI  (DI),
      .FF  (FF),
      .HF  (HF),
      .Cnt (Cnt),
      .OVF (OVF),
      .UNF (UNF),
      .DAV (DAV),
      .FRE (FRE),
      .TD  (TD)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".Cnt"}, 16'(Cnt), 16'(q.size()));
      check({tag, ".DAV"}, 16'(DAV), 16'(q.size() != 0));
      check({tag, ".FF"},  16'(FF),  16'(q.size() == DEPTH));
      check({tag, ".HF"},  16'(HF),  16'(q.size() >= DEPTH/2));
      check({tag, ".OVF"}, 16'(OVF), 16'(m_ovf));
      check({tag, ".UNF"}, 16'(UNF), 16'(m_unf));
      if (q.size() != 0) begin
         check({tag, ".TD"}, 16'(TD), 16'(q[0]));
      end
   endtask

   // One clock: present inputs, advance the model by the FIFO rules, compare
   task automatic step(input string tag, input bit we, input int di, input bit fre, input bit clr);
      bit full, empty;
      WE  = we;
      DI  = W'(di);
      FRE = fre;
      Clr = clr;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      @(posedge Clk);
      if (clr) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (we && full && !fre) m_ovf = 1'b1;
         if (fre && empty)       m_unf = 1'b1;
         if (fre && !empty)      void'(q.pop_front());
         if (we && (!full || fre)) q.push_back(di & 9'h1FF);
      end
      #1;
      WE = 1'b0; FRE = 1'b0; Clr = 1'b0;
      check_all(tag);
   endtask

   initial begin
      // Reset state
      #12;
      check_all("rst");
      Rst = 1'b0;
      @(posedge Clk); #1;
      check_all("idle");

      // Fall-through of a single word, then pop to empty
      step("ft_wr", 1'b1, 'h1AB, 1'b0, 1'b0);
      check("ft_td", 16'(TD), 16'h1AB);
      step("ft_rd", 1'b0, 0, 1'b1, 1'b0);
      check("ft_dav", 16'(DAV), 16'h0);

      // Ordering through the head
      step("ord_w0", 1'b1, 'h002, 1'b0, 1'b0);
      step("ord_w1", 1'b1, 'h000, 1'b0, 1'b0);
      step("ord_w2", 1'b1, 'h0AA, 1'b0, 1'b0);
      step("ord_w3", 1'b1, 'h055, 1'b0, 1'b0);
      check("ord_head", 16'(TD), 16'h002);
      for (int i = 0; i < 4; i++) step("ord_rd", 1'b0, 0, 1'b1, 1'b0);

      // Fill to full, overflow, then write+pop while full
      for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, $urandom_range(0, 511), 1'b0, 1'b0);
      check("full_ff", 16'(FF), 16'h1);
      step("ovf", 1'b1, 'h1FF, 1'b0, 1'b0);
      check("ovf_flag", 16'(OVF), 16'h1);
      step("full_wr_rd", 1'b1, 'h123, 1'b1, 1'b0);
      step("full_wr_rd2", 1'b1, 'h0F0, 1'b1, 1'b0);
      check("full_cnt", 16'(Cnt), 16'd16);

      // Drain, underflow, then 40 words streamed through (pointers wrap twice)
      for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 0, 1'b1, 1'b0);
      step("unf", 1'b0, 0, 1'b1, 1'b0);
      check("unf_flag", 16'(UNF), 16'h1);
      step("wrap_w0", 1'b1, 100, 1'b0, 1'b0);
      for (int i = 1; i < 40; i++) step("wrap", 1'b1, 100 + i, 1'b1, 1'b0);
      step("wrap_last", 1'b0, 0, 1'b1, 1'b0);
      check("wrap_cnt", 16'(Cnt), 16'd0);

      // Underflow with simultaneous write: write still lands
      step("unf_wr", 1'b1, 'h0C3, 1'b1, 1'b0);
      check("unf_wr_cnt", 16'(Cnt), 16'd1);

      // Clr priority over WE and FRE with Cnt=7 and OVF set
      step("clr0", 1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step("cfill", 1'b1, 200 + i, 1'b0, 1'b0);
      step("covf", 1'b1, 'h111, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step("cpop", 1'b0, 0, 1'b1, 1'b0);
      check("clr_pre_cnt", 16'(Cnt), 16'd7);
      step("clr", 1'b1, 'h1EE, 1'b1, 1'b1);
      check("clr_cnt", 16'(Cnt), 16'd0);
      check("clr_ovf", 16'(OVF), 16'h0);
      step("clr_after", 1'b1, 'h035, 1'b0, 1'b0);
      check("clr_td", 16'(TD), 16'h035);
      step("clr_pop", 1'b0, 0, 1'b1, 1'b0);

      // Random traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         step("rnd", 1'($urandom_range(0, 99) < 55), $urandom_range(0, 511),
              1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));
      end

      // Asynchronous reset in the middle of a fill
      step("rst_clr", 1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step("rfill", 1'b1, 300 + i, 1'b0, 1'b0);
      check("rfill_cnt", 16'(Cnt), 16'd5);
      #2 Rst = 1'b1;
      #1;
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      check_all("async_rst");
      @(posedge Clk);
      #4 Rst = 1'b0;
      @(posedge Clk); #1;
      check_all("post_rst");
      step("post_rst_wr", 1'b1, 'h077, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_spi_tx_fifo
